// File: rtl/eth_rx_pingpong_buf.sv
// Packs received bytes into 32-bit words and stores frames in two ping-pong banks for the host.
// Optional ETH_RX_CRC_STRIP_EN: reported frame length excludes the 4 FCS bytes.
module eth_rx_pingpong_buf #(
  parameter int unsigned DEPTH_WORDS = 384,
  parameter int unsigned LEN_W       = 11,
  parameter int unsigned DROP_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_dv_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_sof_i,
  input  logic                  rx_eof_i,
  input  logic                  rx_err_i,
  input  logic                  host_rd_en_i,
  input  logic [8:0]            host_ar_i,
  output logic [31:0]           host_qr_o,
  output logic                  host_rdy_o,
  output logic                  host_bank_o,
  output logic [LEN_W-1:0]      host_len_o,
  output logic                  host_err_o,
  input  logic                  host_release_i,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  localparam int unsigned MAX_BYTES = 4 * DEPTH_WORDS;
  localparam int unsigned CNT_W     = $clog2(MAX_BYTES + 2);
  localparam int unsigned PTR_W     = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StRecv, StDrop, StCommit} state_e;

  state_e                 state_q;
  logic                   wr_bank_q, rd_bank_q;
  logic [1:0]             full_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [23:0]            pack_q;
  logic                   trunc_q, err_eof_q;
  logic [LEN_W-1:0]       len_q [2];
  logic [1:0]             err_q;
  logic [DROP_CNT_W-1:0]  drop_cnt_q;
  logic                   rdy_q;
  logic [31:0]            qr_q;
  logic [31:0]            mem [2][DEPTH_WORDS];

  logic                   sof_seen, start, accept, in_range, we, release_ok;
  logic [CNT_W-1:0]       cnt_next, byte_idx, stored_len;
  logic [1:0]             lane;
  logic [PTR_W-1:0]       ptr;
  logic [31:0]            wdata;
  logic [LEN_W-1:0]       commit_len;

  assign sof_seen   = rx_dv_i & rx_sof_i;
  assign release_ok = host_release_i & rdy_q;

  always_comb begin
    start = 1'b0;
    case (state_q)
      StIdle, StDrop: start = sof_seen & ~full_q[wr_bank_q];
      StRecv:         start = sof_seen;
      default:        start = 1'b0;
    endcase
    accept = start | ((state_q == StRecv) & rx_dv_i);
  end

  // Count saturates one past the bank capacity so overflow stays visible until eof.
  always_comb begin
    if (start) begin
      cnt_next = CNT_W'(1);
    end else if (cnt_q == CNT_W'(MAX_BYTES + 1)) begin
      cnt_next = cnt_q;
    end else begin
      cnt_next = cnt_q + CNT_W'(1);
    end
    in_range = (cnt_next <= CNT_W'(MAX_BYTES));
    byte_idx = cnt_next - CNT_W'(1);
    lane     = byte_idx[1:0];
    ptr      = PTR_W'(byte_idx >> 2);
    we       = accept & in_range & ((lane == 2'd3) | rx_eof_i);
    case (lane)
      2'd0:    wdata = {24'd0, rx_data_i};
      2'd1:    wdata = {16'd0, rx_data_i, pack_q[7:0]};
      2'd2:    wdata = {8'd0, rx_data_i, pack_q[15:0]};
      default: wdata = {rx_data_i, pack_q};
    endcase
  end

  always_comb begin
    stored_len = (cnt_q > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : cnt_q;
`ifdef ETH_RX_CRC_STRIP_EN
    commit_len = (stored_len >= CNT_W'(4)) ? LEN_W'(stored_len - CNT_W'(4)) : '0;
`else
    commit_len = LEN_W'(stored_len);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= 2'b00;
      cnt_q      <= '0;
      pack_q     <= '0;
      trunc_q    <= 1'b0;
      err_eof_q  <= 1'b0;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      err_q      <= 2'b00;
      drop_cnt_q <= '0;
      rdy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDrop: begin
          if (start) begin
            state_q <= rx_eof_i ? StCommit : StRecv;
          end else if (sof_seen) begin
            if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
            state_q <= rx_eof_i ? StIdle : StDrop;
          end else if ((state_q == StDrop) && rx_dv_i && rx_eof_i) begin
            state_q <= StIdle;
          end
        end
        StRecv: begin
          if (rx_dv_i && rx_eof_i) state_q <= StCommit;
        end
        default: begin
          full_q[wr_bank_q] <= 1'b1;
          len_q[wr_bank_q]  <= commit_len;
          err_q[wr_bank_q]  <= err_eof_q | trunc_q;
          wr_bank_q         <= ~wr_bank_q;
          state_q           <= StIdle;
        end
      endcase

      if (accept) begin
        cnt_q   <= cnt_next;
        trunc_q <= start ? ~in_range : (trunc_q | ~in_range);
        if (rx_eof_i) err_eof_q <= rx_err_i;
        if (in_range) begin
          case (lane)
            2'd0:    pack_q[7:0]   <= rx_data_i;
            2'd1:    pack_q[15:8]  <= rx_data_i;
            2'd2:    pack_q[23:16] <= rx_data_i;
            default: ;
          endcase
        end
      end

      // Commit always targets the other bank, so this never collides with the set above.
      if (release_ok) begin
        full_q[rd_bank_q] <= 1'b0;
        rd_bank_q         <= ~rd_bank_q;
      end
      rdy_q <= release_ok ? full_q[~rd_bank_q] : full_q[rd_bank_q];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_bank_q][ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qr_q <= '0;
    end else if (host_rd_en_i) begin
      qr_q <= (32'(host_ar_i) < DEPTH_WORDS) ? mem[rd_bank_q][host_ar_i] : '0;
    end
  end

  assign host_qr_o   = qr_q;
  assign host_rdy_o  = rdy_q;
  assign host_bank_o = rd_bank_q;
  assign host_len_o  = rdy_q ? len_q[rd_bank_q] : '0;
  assign host_err_o  = rdy_q & err_q[rd_bank_q];
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_pingpong_buf.sv
// Directed bench for eth_rx_pingpong_buf: frame storage, ping-pong, drop, truncation, abort, reset.
module tb_eth_rx_pingpong_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        rx_sof_i = 1'b0;
  logic        rx_eof_i = 1'b0;
  logic        rx_err_i = 1'b0;
  logic        host_rd_en_i = 1'b0;
  logic [8:0]  host_ar_i = '0;
  logic [31:0] host_qr_o;
  logic        host_rdy_o;
  logic        host_bank_o;
  logic [10:0] host_len_o;
  logic        host_err_o;
  logic        host_release_i = 1'b0;
  logic [15:0] drop_cnt_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] rd;

  eth_rx_pingpong_buf dut (
    .clk            (clk),
    .rst            (rst),
    .rx_dv_i        (rx_dv_i),
    .rx_data_i      (rx_data_i),
    .rx_sof_i       (rx_sof_i),
    .rx_eof_i       (rx_eof_i),
    .rx_err_i       (rx_err_i),
    .host_rd_en_i   (host_rd_en_i),
    .host_ar_i      (host_ar_i),
    .host_qr_o      (host_qr_o),
    .host_rdy_o     (host_rdy_o),
    .host_bank_o    (host_bank_o),
    .host_len_o     (host_len_o),
    .host_err_o     (host_err_o),
    .host_release_i (host_release_i),
    .drop_cnt_o     (drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_len(input int n);
    int s;
    s = (n > 1536) ? 1536 : n;
`ifdef ETH_RX_CRC_STRIP_EN
    s = (s >= 4) ? s - 4 : 0;
`endif
    return 32'(s);
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic put_byte(input logic [7:0] b, input logic sof, input logic eof, input logic err);
    @(negedge clk);
    rx_dv_i   = 1'b1;
    rx_data_i = b;
    rx_sof_i  = sof;
    rx_eof_i  = eof;
    rx_err_i  = err;
  endtask

  // Returns at the negedge just after the eof byte was sampled, with the bus idle.
  task automatic send_frame(input int n, input logic [7:0] first, input logic err);
    for (int i = 0; i < n; i++) begin
      put_byte(8'(first + 8'(i)), i == 0, i == n - 1, err && (i == n - 1));
    end
    @(negedge clk);
    rx_dv_i  = 1'b0;
    rx_sof_i = 1'b0;
    rx_eof_i = 1'b0;
    rx_err_i = 1'b0;
  endtask

  task automatic read_word(input logic [8:0] a, output logic [31:0] d);
    @(negedge clk);
    host_rd_en_i = 1'b1;
    host_ar_i    = a;
    @(negedge clk);
    host_rd_en_i = 1'b0;
    d = host_qr_o;
  endtask

  task automatic release_bank();
    @(negedge clk);
    host_release_i = 1'b1;
    @(negedge clk);
    host_release_i = 1'b0;
  endtask

  initial begin
    tick(2);
    chk("rst_rdy", 32'(host_rdy_o), 32'd0);
    chk("rst_qr", host_qr_o, 32'd0);
    rst = 1'b0;
    tick(1);
    chk("rst_bank", 32'(host_bank_o), 32'd0);
    chk("rst_len", 32'(host_len_o), 32'd0);
    chk("rst_err", 32'(host_err_o), 32'd0);
    chk("rst_drop", 32'(drop_cnt_o), 32'd0);

    // 64-byte frame, checks the two-cycle rdy latency
    send_frame(64, 8'h00, 1'b0);
    tick(1);
    chk("f64_rdy_early", 32'(host_rdy_o), 32'd0);
    tick(1);
    chk("f64_rdy", 32'(host_rdy_o), 32'd1);
    chk("f64_bank", 32'(host_bank_o), 32'd0);
    chk("f64_len", 32'(host_len_o), exp_len(64));
    chk("f64_err", 32'(host_err_o), 32'd0);
    read_word(9'd0, rd);
    chk("f64_w0", rd, 32'h03020100);
    read_word(9'd15, rd);
    chk("f64_w15", rd, 32'h3F3E3D3C);
    read_word(9'd400, rd);
    chk("f64_oob", rd, 32'h0);
    release_bank();
    chk("rel1_bank", 32'(host_bank_o), 32'd1);
    chk("rel1_rdy", 32'(host_rdy_o), 32'd0);
    release_bank();
    chk("rel_ignored", 32'(host_bank_o), 32'd1);

    // 61-byte frame lands in bank 1 with a zero-padded last word
    send_frame(61, 8'h00, 1'b0);
    tick(2);
    chk("f61_rdy", 32'(host_rdy_o), 32'd1);
    chk("f61_bank", 32'(host_bank_o), 32'd1);
    chk("f61_len", 32'(host_len_o), exp_len(61));
    read_word(9'd14, rd);
    chk("f61_w14", rd, 32'h3B3A3938);
    read_word(9'd15, rd);
    chk("f61_w15", rd, 32'h0000003C);
    release_bank();

    // three frames, no release: third is dropped
    send_frame(100, 8'h10, 1'b0);
    send_frame(100, 8'h80, 1'b0);
    send_frame(100, 8'hC0, 1'b0);
    tick(2);
    chk("drop_cnt", 32'(drop_cnt_o), 32'd1);
    chk("b2b_bank", 32'(host_bank_o), 32'd0);
    chk("b2b_len0", 32'(host_len_o), exp_len(100));
    read_word(9'd0, rd);
    chk("b2b_w0_bank0", rd, 32'h13121110);
    release_bank();
    chk("b2b_rdy1", 32'(host_rdy_o), 32'd1);
    chk("b2b_bank1", 32'(host_bank_o), 32'd1);
    chk("b2b_len1", 32'(host_len_o), exp_len(100));
    read_word(9'd0, rd);
    chk("b2b_w0_bank1", rd, 32'h83828180);
    release_bank();
    chk("b2b_empty", 32'(host_rdy_o), 32'd0);

    // oversize frame truncated to the bank capacity
    send_frame(1600, 8'h00, 1'b0);
    tick(2);
    chk("big_bank", 32'(host_bank_o), 32'd0);
    chk("big_len", 32'(host_len_o), exp_len(1600));
    chk("big_err", 32'(host_err_o), 32'd1);
    read_word(9'd383, rd);
    chk("big_w383", rd, 32'hFFFEFDFC);
    release_bank();

    // MAC error on eof
    send_frame(30, 8'h50, 1'b1);
    tick(2);
    chk("err_bank", 32'(host_bank_o), 32'd1);
    chk("err_flag", 32'(host_err_o), 32'd1);
    chk("err_len", 32'(host_len_o), exp_len(30));
    release_bank();

    // sof at byte 10 aborts the first frame; only the 20-byte frame commits
    for (int i = 0; i < 10; i++) put_byte(8'(8'hA0 + 8'(i)), i == 0, 1'b0, 1'b0);
    send_frame(20, 8'h40, 1'b0);
    tick(2);
    chk("abort_bank", 32'(host_bank_o), 32'd0);
    chk("abort_len", 32'(host_len_o), exp_len(20));
    chk("abort_err", 32'(host_err_o), 32'd0);
    read_word(9'd0, rd);
    chk("abort_w0", rd, 32'h43424140);
    release_bank();
    chk("abort_single", 32'(host_rdy_o), 32'd0);

    // reset in the middle of a frame with another frame committed
    send_frame(64, 8'h00, 1'b0);
    tick(2);
    chk("pre_rst_rdy", 32'(host_rdy_o), 32'd1);
    for (int i = 0; i < 30; i++) put_byte(8'(i), i == 0, 1'b0, 1'b0);
    @(negedge clk);
    rx_dv_i  = 1'b0;
    rx_sof_i = 1'b0;
    rst      = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("mid_rst_rdy", 32'(host_rdy_o), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt_o), 32'd0);
    chk("mid_rst_bank", 32'(host_bank_o), 32'd0);
    send_frame(64, 8'h20, 1'b0);
    tick(2);
    chk("post_rst_rdy", 32'(host_rdy_o), 32'd1);
    chk("post_rst_bank", 32'(host_bank_o), 32'd0);
    chk("post_rst_len", 32'(host_len_o), exp_len(64));
    read_word(9'd0, rd);
    chk("post_rst_w0", rd, 32'h23222120);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
